walk_light_scheduler: RTL and testbench

//  Intersection phase scheduler for the pedestrian walk request latches.

---
 rtl/walk_light_scheduler_if.sv | 22 ++
 rtl/walk_light_scheduler.sv | 135 +++++++++++++
 tb/tb_walk_light_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/walk_light_scheduler_if.sv
// Signal bundle between the walk-light scheduler, the walk request latches and the lamps.
// The scheduler connects through the slave modport; the environment drives through master.
interface walk_light_scheduler_if;
  logic       walk_req_1;
  logic       walk_req_2;
  logic       side_car;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_1;
  logic       walk_2;
  logic       wr_reset;

  modport master (
    output walk_req_1, walk_req_2, side_car,
    input  main_light, side_light, walk_1, walk_2, wr_reset
  );

  modport slave (
    input  walk_req_1, walk_req_2, side_car,
    output main_light, side_light, walk_1, walk_2, wr_reset
  );
endinterface

// File: rtl/walk_light_scheduler.sv
// Intersection phase scheduler: main/side light sequencing plus an all-red walk phase.
// Optional feature macro: FLASH_DONT_WALK_EN (flash the walk outputs at the end of WALK).
module walk_light_scheduler #(
  parameter int CNT_W        = 8,
  parameter int GREEN_MIN    = 8,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int SIDE_GREEN_T = 6,
  parameter int WALK_T       = 5,
  parameter int FLASH_T      = 2
) (
  input  logic                  clk,
  input  logic                  g_reset,
  walk_light_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_MG, S_MY, S_AR1, S_SG, S_SY, S_AR2, S_WALK
  } state_e;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

`ifdef FLASH_DONT_WALK_EN
  localparam int FLASH_N = FLASH_T;
`else
  localparam int FLASH_N = FLASH_T * 0;  // zero-length flash window: walk stays solid
`endif

  function automatic logic [CNT_W-1:0] dur_m1(state_e s);
    case (s)
      S_MG:        dur_m1 = CNT_W'(GREEN_MIN - 1);
      S_MY, S_SY:  dur_m1 = CNT_W'(YELLOW_T - 1);
      S_SG:        dur_m1 = CNT_W'(SIDE_GREEN_T - 1);
      S_WALK:      dur_m1 = CNT_W'(WALK_T - 1);
      default:     dur_m1 = CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             cap1_q, cap1_d, cap2_q, cap2_d;
  logic             toggle_q, toggle_d;
  logic [2:0]       main_light_q, main_light_d;
  logic [2:0]       side_light_q, side_light_d;
  logic             walk_1_q, walk_1_d, walk_2_q, walk_2_d;
  logic             wr_reset_q, wr_reset_d;

  logic any_walk, timer_done, entering, walk_next, flash_next;

  // NOTE: every always_comb output is assigned a default first so no path can infer a latch.
  always_comb begin
    any_walk   = bus.walk_req_1 | bus.walk_req_2;
    timer_done = (timer_q == '0);
    state_d    = state_q;

    case (state_q)
      S_MG:   if (timer_done && (bus.side_car || any_walk)) state_d = S_MY;
      S_MY:   if (timer_done) state_d = S_AR1;
      S_AR1:  if (timer_done) state_d = bus.side_car ? S_SG : (any_walk ? S_WALK : S_MG);
      S_SG:   if (timer_done) state_d = S_SY;
      S_SY:   if (timer_done) state_d = S_AR2;
      S_AR2:  if (timer_done) state_d = any_walk ? S_WALK : S_MG;
      S_WALK: if (timer_done) state_d = S_MG;
      default: state_d = S_AR1;
    endcase

    // No state transitions to itself, so a state change always marks a fresh entry.
    entering = (state_d != state_q);
    timer_d  = entering ? dur_m1(state_d) : (timer_done ? '0 : timer_q - 1'b1);

    walk_next  = (state_d == S_WALK);
    cap1_d     = cap1_q;
    cap2_d     = cap2_q;
    toggle_d   = toggle_q;
    if (entering && walk_next) begin
      cap1_d   = bus.walk_req_1;
      cap2_d   = bus.walk_req_2;
      toggle_d = 1'b1;
    end else if (state_q == S_WALK && int'(timer_q) < FLASH_N) begin
      toggle_d = ~toggle_q;
    end

    // The first flash cycle shows the entry value of toggle, then it alternates.
    flash_next = walk_next && (int'(timer_d) < FLASH_N);
    walk_1_d   = walk_next && cap1_d && (!flash_next || toggle_d);
    walk_2_d   = walk_next && cap2_d && (!flash_next || toggle_d);
    wr_reset_d = entering && walk_next;

    main_light_d = L_RED;
    side_light_d = L_RED;
    case (state_d)
      S_MG:    main_light_d = L_GREEN;
      S_MY:    main_light_d = L_YELLOW;
      S_SG:    side_light_d = L_GREEN;
      S_SY:    side_light_d = L_YELLOW;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      state_q      <= S_AR1;
      timer_q      <= CNT_W'(ALLRED_T - 1);
      cap1_q       <= 1'b0;
      cap2_q       <= 1'b0;
      toggle_q     <= 1'b1;
      main_light_q <= L_RED;
      side_light_q <= L_RED;
      walk_1_q     <= 1'b0;
      walk_2_q     <= 1'b0;
      wr_reset_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cap1_q       <= cap1_d;
      cap2_q       <= cap2_d;
      toggle_q     <= toggle_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      walk_1_q     <= walk_1_d;
      walk_2_q     <= walk_2_d;
      wr_reset_q   <= wr_reset_d;
    end
  end

  assign bus.main_light = main_light_q;
  assign bus.side_light = side_light_q;
  assign bus.walk_1     = walk_1_q;
  assign bus.walk_2     = walk_2_q;
  assign bus.wr_reset   = wr_reset_q;

endmodule

// File: tb/tb_walk_light_scheduler.sv
// Directed bench for walk_light_scheduler; expected phase lengths are hand-derived.
// Expects solid or flashing walk outputs depending on FLASH_DONT_WALK_EN.
module tb_walk_light_scheduler;

  logic clk = 1'b0;
  logic g_reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_viol   = 0;

  walk_light_scheduler_if bus ();

  walk_light_scheduler dut (
    .clk     (clk),
    .g_reset (g_reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the current cycle and the following n-1, leaving the bench at the next phase's first sample.
  task automatic expect_phase(input string tag, input logic [2:0] m, input logic [2:0] s,
                              input logic w1, input logic w2, input logic wr, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_main"}, 8'(bus.main_light), 8'(m));
      check({tag, "_side"}, 8'(bus.side_light), 8'(s));
      check({tag, "_w1"},   8'(bus.walk_1),     8'(w1));
      check({tag, "_w2"},   8'(bus.walk_2),     8'(w2));
      check({tag, "_wr"},   8'(bus.wr_reset),   8'(wr));
      step();
    end
  endtask

  // Safety monitor: one-hot lamps and never both directions non-red.
  always @(negedge clk) begin
    if (g_reset) begin
      if (!$onehot(bus.main_light) || !$onehot(bus.side_light)) n_viol++;
      if (!bus.main_light[2] && !bus.side_light[2]) n_viol++;
    end
  end

  initial begin
    g_reset        = 1'b0;
    bus.walk_req_1 = 1'b0;
    bus.walk_req_2 = 1'b0;
    bus.side_car   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_phase("reset", R, R, 0, 0, 0, 1);
    g_reset = 1'b1;

    // 1: idle -> AR1 two cycles, then MG held
    expect_phase("idle_ar1", R, R, 0, 0, 0, 2);
    // 2: side car from MG entry
    bus.side_car = 1'b1;
    expect_phase("t2_mg",  G, R, 0, 0, 0, 8);
    expect_phase("t2_my",  Y, R, 0, 0, 0, 3);
    expect_phase("t2_ar1", R, R, 0, 0, 0, 2);
    expect_phase("t2_sg",  R, G, 0, 0, 0, 6);
    expect_phase("t2_sy",  R, Y, 0, 0, 0, 3);
    expect_phase("t2_ar2", R, R, 0, 0, 0, 2);
    bus.side_car = 1'b0;
    expect_phase("mg_hold", G, R, 0, 0, 0, 20);

    // 3: walk request 1 only
    bus.walk_req_1 = 1'b1;
    expect_phase("t3_mg",  G, R, 0, 0, 0, 1);
    expect_phase("t3_my",  Y, R, 0, 0, 0, 3);
    expect_phase("t3_ar1", R, R, 0, 0, 0, 2);
    expect_phase("t3_walk_first", R, R, 1, 0, 1, 1);
    bus.walk_req_1 = 1'b0;  // latch cleared by wr_reset
`ifdef FLASH_DONT_WALK_EN
    expect_phase("t3_walk", R, R, 1, 0, 0, 3);
    expect_phase("t3_walk_flash_off", R, R, 0, 0, 0, 1);
`else
    expect_phase("t3_walk", R, R, 1, 0, 0, 4);
`endif
    expect_phase("t3_mg_after", G, R, 0, 0, 0, 10);

    // 4: side car and walk request 2 together: side first, then walk 2
    bus.side_car   = 1'b1;
    bus.walk_req_2 = 1'b1;
    expect_phase("t4_mg",  G, R, 0, 0, 0, 1);
    expect_phase("t4_my",  Y, R, 0, 0, 0, 3);
    expect_phase("t4_ar1", R, R, 0, 0, 0, 2);
    bus.side_car = 1'b0;
    expect_phase("t4_sg",  R, G, 0, 0, 0, 6);
    expect_phase("t4_sy",  R, Y, 0, 0, 0, 3);
    expect_phase("t4_ar2", R, R, 0, 0, 0, 2);
    expect_phase("t4_walk_first", R, R, 0, 1, 1, 1);
    bus.walk_req_2 = 1'b0;
`ifdef FLASH_DONT_WALK_EN
    expect_phase("t4_walk", R, R, 0, 1, 0, 3);
    expect_phase("t4_walk_flash_off", R, R, 0, 0, 0, 1);
`else
    expect_phase("t4_walk", R, R, 0, 1, 0, 4);
`endif
    expect_phase("t4_mg_after", G, R, 0, 0, 0, 10);

    // 5: reset asserted in the middle of side green
    bus.side_car = 1'b1;
    expect_phase("t5_mg",  G, R, 0, 0, 0, 1);
    expect_phase("t5_my",  Y, R, 0, 0, 0, 3);
    expect_phase("t5_ar1", R, R, 0, 0, 0, 2);
    expect_phase("t5_sg",  R, G, 0, 0, 0, 2);
    g_reset = 1'b0;
    #1;
    expect_phase("t5_abort", R, R, 0, 0, 0, 1);
    bus.side_car = 1'b0;
    g_reset = 1'b1;
    expect_phase("t5_ar1_again", R, R, 0, 0, 0, 2);
    expect_phase("t5_mg_again",  G, R, 0, 0, 0, 5);

    check("safety_violations", 8'(n_viol), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
